aes_key_sched_mc: RTL and testbench

Multi-context, word-serial AES key schedule for AES-128, AES-192 and AES-256. It expands a cipher key into round-key words and stores them in one of NUM_CTX independent key slots. A cipher core can read the finished round keys of any slot while another slot is being expanded. It sits between the key-load interface and the AES round datapath, and borrows one 32-bit S-box lookup per cycle from the shared S-box.

---
 rtl/aes_key_sched_mc_pkg.sv | 51 +++++
 rtl/aes_key_sched_mc_if.sv | 32 +++
 rtl/aes_key_sched_mc_word_mem.sv | 59 +++++
 rtl/aes_key_sched_mc.sv | 148 ++++++++++++++
 tb/tb_aes_key_sched_mc.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_sched_mc_pkg.sv
// Shared types and helpers for the multi-context AES key schedule:
// keylen codes, per-keylen geometry, FSM encoding and GF(2^8) xtime.
package aes_key_sched_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;
  localparam logic [1:0] KEYLEN_BAD = 2'd3;

  localparam int MAX_WORDS = 60;
  localparam int WIDX_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: nk_of = 4'd4;
      KEYLEN_192: nk_of = 4'd6;
      KEYLEN_256: nk_of = 4'd8;
      default:    nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: nr_of = 4'd10;
      KEYLEN_192: nr_of = 4'd12;
      KEYLEN_256: nr_of = 4'd14;
      default:    nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [WIDX_W-1:0] ntot_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: ntot_of = 6'd44;
      KEYLEN_192: ntot_of = 6'd52;
      KEYLEN_256: ntot_of = 6'd60;
      default:    ntot_of = 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

endpackage

// File: rtl/aes_key_sched_mc_if.sv
// Key-load, slot-control, read and S-box borrow signals of the key schedule.
interface aes_key_sched_mc_if #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
);
  logic               init;
  logic [CTX_W-1:0]   init_ctx;
  logic [1:0]         keylen;
  logic [255:0]       key;
  logic               init_ack;
  logic               init_err;
  logic               clr;
  logic [CTX_W-1:0]   clr_ctx;
  logic               busy;
  logic [NUM_CTX-1:0] ready;
  logic [CTX_W-1:0]   rd_ctx;
  logic [3:0]         rd_round;
  logic [127:0]       round_key;
  logic               rd_valid;
  logic [31:0]        sboxw;
  logic [31:0]        new_sboxw;

  modport master (
    output init, init_ctx, keylen, key, clr, clr_ctx, rd_ctx, rd_round, new_sboxw,
    input  init_ack, init_err, busy, ready, round_key, rd_valid, sboxw
  );

  modport slave (
    input  init, init_ctx, keylen, key, clr, clr_ctx, rd_ctx, rd_round, new_sboxw,
    output init_ack, init_err, busy, ready, round_key, rd_valid, sboxw
  );
endinterface

// File: rtl/aes_key_sched_mc_word_mem.sv
// Per-slot round-key word store: one word write port, one combinational
// four-word (one round key) read port, plus the keylen of each slot.
module aes_key_word_mem
  import aes_key_sched_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [CTX_W-1:0]  wr_ctx,
  input  logic [WIDX_W-1:0] wr_idx,
  input  logic [31:0]       wr_data,
  input  logic              kl_en,
  input  logic [CTX_W-1:0]  kl_ctx,
  input  logic [1:0]        kl_val,
  input  logic [CTX_W-1:0]  rd_ctx,
  input  logic [3:0]        rd_round,
  output logic [127:0]      rd_data,
  output logic [1:0]        rd_keylen
);

  logic [31:0]       mem_r    [NUM_CTX][MAX_WORDS];
  logic [1:0]        keylen_r [NUM_CTX];
  logic [31:0]       rd_word_s [4];
  logic [WIDX_W-1:0] base_s;
  logic              rd_ctx_ok_s;

  // Word and keylen writes; the array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_ctx) < NUM_CTX) && (int'(wr_idx) < MAX_WORDS)) begin
      mem_r[wr_ctx][wr_idx] <= wr_data;
    end
    if (kl_en && (int'(kl_ctx) < NUM_CTX)) begin
      keylen_r[kl_ctx] <= kl_val;
    end
  end

  assign base_s      = {rd_round, 2'b00};
  assign rd_ctx_ok_s = (int'(rd_ctx) < NUM_CTX);

  // Round indices past the last stored word read as zero.
  for (genvar k = 0; k < 4; k++) begin : g_rd
    logic [WIDX_W-1:0] idx_s;
    assign idx_s = base_s + 6'(k);
    // One word of the addressed round key.
    always_comb begin
      if (rd_ctx_ok_s && (idx_s < 6'(MAX_WORDS))) begin
        rd_word_s[k] = mem_r[rd_ctx][idx_s];
      end else begin
        rd_word_s[k] = 32'd0;
      end
    end
  end

  assign rd_data   = {rd_word_s[0], rd_word_s[1], rd_word_s[2], rd_word_s[3]};
  assign rd_keylen = rd_ctx_ok_s ? keylen_r[rd_ctx] : KEYLEN_128;

endmodule

// File: rtl/aes_key_sched_mc.sv
// Word-serial AES-128/192/256 key expansion into one of NUM_CTX key slots,
// with a zero-latency round-key read port usable while another slot expands.
module aes_key_sched_mc
  import aes_key_sched_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input logic               clk,
  input logic               reset,
  aes_key_sched_mc_if.slave bus
);

  state_e             state_r;
  logic [WIDX_W-1:0]  idx_r;
  logic [2:0]         kmod_r;
  logic [7:0]         rcon_r;
  logic [255:0]       key_r;
  logic [1:0]         keylen_r;
  logic [CTX_W-1:0]   ctx_r;
  logic [31:0]        win_r [8];
  logic [NUM_CTX-1:0] ready_r;
  logic               init_err_r;

  logic [3:0]         nk_s;
  logic [2:0]         back_s;
  logic [WIDX_W-1:0]  ntot_s;
  logic               accept_s, abort_s, we_s, rd_valid_s;
  logic [31:0]        temp_s, t_s, sboxw_s, word_s;
  logic [1:0]         rd_keylen_s;
  logic [127:0]       rd_data_s;

  assign nk_s     = nk_of(keylen_r);
  assign back_s   = 3'(nk_s - 4'd1);
  assign ntot_s   = ntot_of(keylen_r);
  assign temp_s   = win_r[0];
  assign we_s     = (state_r == ST_LOAD) || (state_r == ST_GEN);
  assign accept_s = (state_r == ST_IDLE) && bus.init && (bus.keylen != KEYLEN_BAD) &&
                    !(bus.clr && (bus.clr_ctx == bus.init_ctx));
  assign abort_s  = bus.clr && (state_r != ST_IDLE) && (bus.clr_ctx == ctx_r);

  // Next schedule word; win_r[nk-1] is w[i-Nk].
  always_comb begin
    sboxw_s = 32'd0;
    t_s     = temp_s;
    word_s  = 32'd0;
    case (state_r)
      ST_LOAD: word_s = key_r[255:224];
      ST_GEN: begin
        if (kmod_r == 3'd0) begin
          sboxw_s = {temp_s[23:0], temp_s[31:24]};
          t_s     = bus.new_sboxw ^ {rcon_r, 24'h000000};
        end else if ((nk_s == 4'd8) && (kmod_r == 3'd4)) begin
          sboxw_s = temp_s;
          t_s     = bus.new_sboxw;
        end else begin
          sboxw_s = 32'd0;
          t_s     = temp_s;
        end
        word_s = win_r[back_s] ^ t_s;
      end
      default: word_s = 32'd0;
    endcase
  end

  // Control FSM, word window, slot ready flags and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ready_r    <= '0;
      init_err_r <= 1'b0;
      rcon_r     <= 8'h01;
      idx_r      <= 6'd0;
      kmod_r     <= 3'd0;
      key_r      <= 256'd0;
      keylen_r   <= KEYLEN_128;
      ctx_r      <= '0;
      for (int k = 0; k < 8; k++) win_r[k] <= 32'd0;
    end else begin
      init_err_r <= (state_r == ST_IDLE) && bus.init && (bus.keylen == KEYLEN_BAD);
      if (we_s) begin
        for (int k = 7; k > 0; k--) win_r[k] <= win_r[k-1];
        win_r[0] <= word_s;
        idx_r    <= idx_r + 6'd1;
        kmod_r   <= (kmod_r == back_s) ? 3'd0 : kmod_r + 3'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            key_r             <= bus.key;
            keylen_r          <= bus.keylen;
            ctx_r             <= bus.init_ctx;
            idx_r             <= 6'd0;
            kmod_r            <= 3'd0;
            rcon_r            <= 8'h01;
            ready_r[bus.init_ctx] <= 1'b0;
            state_r           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          key_r <= {key_r[223:0], 32'h00000000};
          if (idx_r == (6'(nk_s) - 6'd1)) state_r <= ST_GEN;
        end
        ST_GEN: begin
          if (kmod_r == 3'd0) rcon_r <= xtime(rcon_r);
          if (idx_r == (ntot_s - 6'd1)) state_r <= ST_DONE;
        end
        ST_DONE: begin
          ready_r[ctx_r] <= 1'b1;
          state_r        <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
      // clr overrides a completion for the same slot and aborts its expansion.
      if (bus.clr) ready_r[bus.clr_ctx] <= 1'b0;
      if (abort_s) state_r <= ST_IDLE;
    end
  end

  aes_key_word_mem #(
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W)
  ) u_mem (
    .clk       (clk),
    .wr_en     (we_s),
    .wr_ctx    (ctx_r),
    .wr_idx    (idx_r),
    .wr_data   (word_s),
    .kl_en     (accept_s),
    .kl_ctx    (bus.init_ctx),
    .kl_val    (bus.keylen),
    .rd_ctx    (bus.rd_ctx),
    .rd_round  (bus.rd_round),
    .rd_data   (rd_data_s),
    .rd_keylen (rd_keylen_s)
  );

  assign rd_valid_s    = (int'(bus.rd_ctx) < NUM_CTX) && ready_r[bus.rd_ctx] &&
                         (bus.rd_round <= nr_of(rd_keylen_s));
  assign bus.rd_valid  = rd_valid_s;
  assign bus.round_key = rd_valid_s ? rd_data_s : 128'd0;
  assign bus.init_ack  = accept_s;
  assign bus.init_err  = init_err_r;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.ready     = ready_r;
  assign bus.sboxw     = sboxw_s;

endmodule

// File: tb/tb_aes_key_sched_mc.sv
// Self-checking bench for aes_key_sched_mc: combinational S-box, reference
// key expansion feeding a scoreboard, and per-scenario test tasks.
module tb_aes_key_sched_mc;
  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct packed {
    logic [1:0]    ctx;
    logic [3:0]    nr;
    logic [1919:0] rks;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [1919:0] slot_ref [NUM_CTX];
  logic [3:0]    slot_nr  [NUM_CTX];
  logic          slot_ok  [NUM_CTX];

  aes_key_sched_mc_if #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) bus ();

  aes_key_sched_mc #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] tab;
    tab = SBOX_TAB;
    return tab[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb bus.new_sboxw = sub_word(bus.sboxw);

  // Straight textbook expansion into an array of all words.
  function automatic logic [1919:0] model_expand(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    int nk, nr, nt;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    nt = 4 * (nr + 1);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nt; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) res[1919-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NUM_CTX-1:0] exp_ready();
    logic [NUM_CTX-1:0] v;
    for (int s = 0; s < NUM_CTX; s++) v[s] = slot_ok[s];
    return v;
  endfunction

  task automatic start_init(input logic [1:0] ctx, input logic [1:0] kl, input logic [255:0] key);
    exp_t e;
    @(negedge clk);
    bus.init = 1'b1; bus.init_ctx = ctx; bus.keylen = kl; bus.key = key;
    #1;
    checks++;
    if (bus.init_ack !== 1'b1) begin
      failures++; $display("FAIL init_ack ctx=%0d got=%b exp=1", ctx, bus.init_ack);
    end else begin
      e.ctx = ctx; e.nr = 4'(10 + 2 * int'(kl)); e.rks = model_expand(key, kl);
      sb_q.push_back(e);
      slot_ok[ctx] = 1'b0;
    end
    @(posedge clk); #1;
    bus.init = 1'b0;
  endtask

  // Waits for the oldest scoreboard entry to complete, sweeping the read port every cycle.
  task automatic wait_done(input int exp_lat, input int lat0);
    exp_t e;
    int lat, s, r;
    bit seen;
    logic exp_v;
    logic [127:0] exp_rk;
    if (sb_q.size() == 0) begin
      checks++; failures++; $display("FAIL scoreboard_empty got=0 exp=1 entries");
      return;
    end
    e = sb_q.pop_front();
    lat = lat0; seen = 1'b0;
    while (!seen && lat < exp_lat + 8) begin
      @(posedge clk); lat++; #1;
      if (bus.ready[e.ctx] === 1'b1) begin
        seen = 1'b1; slot_ok[e.ctx] = 1'b1; slot_ref[e.ctx] = e.rks; slot_nr[e.ctx] = e.nr;
      end else begin
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_during lat=%0d got=%b exp=1", lat, bus.busy); end
      end
      s = lat % NUM_CTX; r = (lat / NUM_CTX) % 16;
      bus.rd_ctx = CTX_W'(s); bus.rd_round = 4'(r);
      #1;
      exp_v  = slot_ok[s] && (4'(r) <= slot_nr[s]);
      exp_rk = exp_v ? slot_ref[s][1919-128*r -: 128] : 128'h0;
      checks++;
      if (bus.round_key !== exp_rk || bus.rd_valid !== exp_v) begin
        failures++;
        $display("FAIL sweep ctx=%0d rnd=%0d got=%h/%b exp=%h/%b", s, r, bus.round_key, bus.rd_valid, exp_rk, exp_v);
      end
    end
    checks++;
    if (!seen || lat != exp_lat) begin failures++; $display("FAIL latency ctx=%0d got=%0d exp=%0d", e.ctx, lat, exp_lat); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", bus.busy); end
    for (int k = 0; k < 16; k++) begin
      bus.rd_ctx = e.ctx; bus.rd_round = 4'(k);
      #1;
      exp_v  = (4'(k) <= e.nr);
      exp_rk = exp_v ? e.rks[1919-128*k -: 128] : 128'h0;
      checks++;
      if (bus.round_key !== exp_rk || bus.rd_valid !== exp_v) begin
        failures++;
        $display("FAIL round ctx=%0d rnd=%0d got=%h/%b exp=%h/%b", e.ctx, k, bus.round_key, bus.rd_valid, exp_rk, exp_v);
      end
    end
  endtask

  task automatic check_rk(input string name, input logic [1:0] ctx, input logic [3:0] rnd, input logic [127:0] exp_rk);
    bus.rd_ctx = ctx; bus.rd_round = rnd;
    #1;
    checks++;
    if (bus.round_key !== exp_rk) begin failures++; $display("FAIL %s got=%h exp=%h", name, bus.round_key, exp_rk); end
  endtask

  task automatic test_reset();
    bus.init = 1'b0; bus.init_ctx = '0; bus.keylen = 2'd0; bus.key = 256'd0;
    bus.clr = 1'b0; bus.clr_ctx = '0; bus.rd_ctx = '0; bus.rd_round = 4'd0;
    for (int s = 0; s < NUM_CTX; s++) begin slot_ok[s] = 1'b0; slot_nr[s] = 4'd0; slot_ref[s] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 4'b0000 || bus.init_err !== 1'b0) begin
      failures++; $display("FAIL reset_state got=%b/%b/%b exp=0/0000/0", bus.busy, bus.ready, bus.init_err);
    end
    checks++;
    if (bus.round_key !== 128'h0 || bus.rd_valid !== 1'b0 || bus.sboxw !== 32'h0) begin
      failures++; $display("FAIL reset_read got=%h/%b/%h exp=0/0/0", bus.round_key, bus.rd_valid, bus.sboxw);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_aes128();
    start_init(2'd0, 2'd0, K128);
    wait_done(45, 0);
    check_rk("aes128_r10", 2'd0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_rk("aes128_r0", 2'd0, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
  endtask

  task automatic test_aes192();
    start_init(2'd1, 2'd1, K192);
    wait_done(53, 0);
    check_rk("aes192_r12", 2'd1, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d);
    check_rk("aes192_r13", 2'd1, 4'd13, 128'h0);
    checks++;
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL aes192_r13_valid got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_aes256();
    start_init(2'd2, 2'd2, K256);
    wait_done(61, 0);
    check_rk("aes256_r14", 2'd2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
  endtask

  task automatic test_errors();
    @(negedge clk);
    bus.init = 1'b1; bus.init_ctx = 2'd3; bus.keylen = 2'd3; bus.key = rand_key();
    #1;
    checks++;
    if (bus.init_ack !== 1'b0) begin failures++; $display("FAIL bad_keylen_ack got=%b exp=0", bus.init_ack); end
    @(posedge clk); #1;
    bus.init = 1'b0;
    checks++;
    if (bus.init_err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL bad_keylen_err got=%b/%b exp=1/0", bus.init_err, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.init_err !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== exp_ready()) begin
      failures++; $display("FAIL bad_keylen_after got=%b/%b/%b exp=0/0/%b", bus.init_err, bus.busy, bus.ready, exp_ready());
    end
    start_init(2'd3, 2'd0, rand_key());
    @(negedge clk);
    bus.init = 1'b1; bus.init_ctx = 2'd0; bus.keylen = 2'd1; bus.key = rand_key();
    #1;
    checks++;
    if (bus.init_ack !== 1'b0) begin failures++; $display("FAIL busy_init_ack got=%b exp=0", bus.init_ack); end
    @(posedge clk); #1;
    bus.init = 1'b0;
    checks++;
    if (bus.init_err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL busy_init_ignored got=%b/%b exp=0/1", bus.init_err, bus.busy);
    end
    wait_done(45, 1);
  endtask

  task automatic test_clr();
    start_init(2'd2, 2'd2, rand_key());
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b1; bus.clr_ctx = 2'd2;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    void'(sb_q.pop_front());
    slot_ok[2] = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready[2] !== 1'b0) begin
      failures++; $display("FAIL clr_abort got=%b/%b exp=0/0", bus.busy, bus.ready[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== exp_ready()) begin
      failures++; $display("FAIL clr_abort_hold got=%b/%b exp=0/%b", bus.busy, bus.ready, exp_ready());
    end
    start_init(2'd2, 2'd1, rand_key());
    wait_done(53, 0);
    // clr lands in the same cycle the slot would be marked ready
    start_init(2'd1, 2'd0, rand_key());
    repeat (44) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.ready[1] !== 1'b0) begin
      failures++; $display("FAIL pre_done got=%b/%b exp=1/0", bus.busy, bus.ready[1]);
    end
    bus.clr = 1'b1; bus.clr_ctx = 2'd1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    void'(sb_q.pop_front());
    slot_ok[1] = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== exp_ready()) begin
      failures++; $display("FAIL clr_at_done got=%b/%b exp=0/%b", bus.busy, bus.ready, exp_ready());
    end
    @(negedge clk);
    bus.clr = 1'b1; bus.clr_ctx = 2'd0;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    slot_ok[0] = 1'b0;
    check_rk("clr_idle_slot", 2'd0, 4'd0, 128'h0);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.ready !== exp_ready()) begin
      failures++; $display("FAIL clr_idle_ready got=%b/%b exp=0/%b", bus.rd_valid, bus.ready, exp_ready());
    end
  endtask

  task automatic test_reset_mid_gen();
    start_init(2'd3, 2'd0, rand_key());
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int s = 0; s < NUM_CTX; s++) slot_ok[s] = 1'b0;
    sb_q.delete();
    check_rk("reset_mid_read", 2'd2, 4'd0, 128'h0);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 4'b0000 || bus.init_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid_state got=%b/%b/%b exp=0/0000/0", bus.busy, bus.ready, bus.init_err);
    end
    start_init(2'd3, 2'd0, K128);
    wait_done(45, 0);
    check_rk("after_reset_r10", 2'd3, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_errors();
    test_clr();
    test_reset_mid_gen();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
